cpu_mem_stage: RTL and testbench
================================

# cpu_mem_stage

Parametrised pipeline stage 3→4 of the stack CPU: resolves branches, selects the stack push value and pop count, and performs one data-bus read or write per instruction through a req/ack handshake with wait states. While a bus access is in flight it stalls stage 3. It sits between the ALU stage and the stack writeback stage, and drives the iobus master port.

## Interface
- DATA_W, 32, ALU/bus data width
- TAG_W, 3, stack-entry type-tag width; stack entry is TAG_W+DATA_W
- PC_W, 32, program-counter width
- POP_W, 11, pop-count width
- BUS_AW, 8, bus address width
- TIMEOUT, 15, max REQ cycles without ack (≥1)

- clk  in  1  clock
- rst_b  in  1  reset, asynchronous, active-low
- valid_3a  in  1  stage-3 instruction valid
- stall_3a  out  1  stage 3 must hold all *_3a inputs
- alu__cond_3a  in  1  branch condition
- alu__out_3a  in  DATA_W  ALU result / bus address / computed pop count
- c__branch_3a  in  2  UC_BR_NONE/REL/ALU/REL_COND
- c__to_push_3a  in  3  UC_PUSHALU/IMM/REG0/REG1/BUS
- c__bus_3a  in  2  UC_BUS_NONE/RD/WR
- instruction_3a  in  48  instruction word; [15:0] branch offset, [TAG_W+DATA_W-1:0] immediate
- pc_3a  in  PC_W  instruction PC
- r0_3a, r1_3a  in  TAG_W+DATA_W  stack operands; r0 data is write data
- st__to_pop_3a  in  POP_W  pop count, or POP_FROM_ALU (3)
- kill_4a  out  1  flush younger stages (combinational)
- branch_target_4a  out  PC_W  redirect PC (combinational)
- valid_4a, c__to_push_4a, pc_4a, st__to_pop_4a, st__to_push_4a  out  1/3/PC_W/POP_W/TAG_W+DATA_W  registered stage-4 fields
- bus_err_4a  out  1  retired bus access timed out
- bus__req, bus__we  out  1  registered request / write enable
- bus__addr  out  BUS_AW  = alu__out_3a[BUS_AW-1:0], latched
- bus__wrdata  out  DATA_W  = r0_3a[DATA_W-1:0], latched
- bus__ack  in  1  slave completion, 1 cycle
- bus__rddata  in  DATA_W  read data, valid with ack

## Operation
- advance = valid_3a & ~stall_3a.
- kill_4a = advance & (REL|ALU ? 1 : REL_COND ? alu__cond_3a : 0). Unknown encodings: 0.
- branch_target_4a: REL/REL_COND → pc_3a + sign-extended instruction_3a[15:0], truncated to PC_W; ALU → alu__out_3a[PC_W-1:0] (zero-extended if PC_W > DATA_W); otherwise 0.
- On advance, the stage-4 registers load: pc, c__to_push, pop (POP_FROM_ALU → alu__out_3a[POP_W-1:0]), and push value:
  - ALU → {TYPE_INTEGER, alu__out}
  - IMM → instruction[TAG_W+DATA_W-1:0]
  - REG0/REG1 → r0/r1
  - BUS → {TYPE_INTEGER, captured rddata}
  - other → 0
- Stage-4 registers hold otherwise. valid_4a <= advance every cycle.
- Bus FSM states:
  - IDLE: if valid_3a & c__bus≠NONE → stall_3a=1, latch addr/we/wrdata, go to REQ.
  - REQ: bus__req=1, stall_3a=1. On ack → capture rddata, go to DONE. On timeout → capture all-ones, set err, go to DONE.
  - DONE: stall_3a=0; the instruction advances, bus_err_4a loads err; go to IDLE.
- Non-bus instructions never stall. kill_4a for a bus instruction fires only in DONE.
- Address, we and wrdata are stable throughout REQ. req drops the cycle after ack.

## Timing
- Non-bus instruction: 1 cycle, back-to-back throughput.
- Bus access with ack on REQ cycle n: stall for 1+n cycles; advances in DONE. Minimum 3 cycles (ack on the first REQ cycle).
- Ack arriving in IDLE/DONE is ignored.
- Reset (any time, including mid-REQ): FSM→IDLE, bus__req=0, stall_3a=0, all registered outputs 0, valid_4a=0. No ack is awaited afterwards.

## Configuration
- CPU_MEM_TIMEOUT_EN defined: a REQ cycle counter (clog2(TIMEOUT+1) bits, cleared on REQ entry) forces DONE with bus_err after TIMEOUT REQ cycles without ack.
- Undefined: REQ waits indefinitely; bus_err_4a tied 0; no counter.

## Structure
- opcode.vh holds UC_BR_*, UC_PUSH* (adds UC_PUSHBUS), UC_BUS_*, TYPE_INTEGER and POP_FROM_ALU.
- Sub-module cpu_mem_busfsm contains the FSM, latches, timeout counter and captured data.
- Branch logic and the stage-4 registers stay in the top level.

## Test plan
- REL_COND, pc=0x100, offset 0xFFF0, cond=1 → kill_4a=1, target 0xF0. Same with cond=0 → kill_4a=0.
- PUSHIMM, instruction[34:0]=0x5_1234_5678 → st__to_push_4a=0x512345678, valid_4a=1 next cycle, no stall.
- st__to_pop_3a=3, alu__out=0x42 → st__to_pop_4a=0x42. st__to_pop_3a=2 → 2.
- RD at alu__out=0x1C, ack after 4 REQ cycles with rddata=0xDEADBEEF → stall 5 cycles, bus__addr=0x1C stable, push={TYPE_INTEGER,0xDEADBEEF}.
- With CPU_MEM_TIMEOUT_EN and TIMEOUT=15, no ack → req drops after 15 REQ cycles, bus_err_4a=1, push data 0xFFFFFFFF.
- Reset asserted on the 2nd REQ cycle of a WR → req=0, stall=0, outputs 0. A late ack is ignored.

Source files
------------

// File: rtl/cpu_mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// cpu_mem_stage_pkg
// Purpose : Shared micro-op encodings, type tags and bus FSM state type for
//           the stack CPU memory stage (stage 3 -> 4).
// Contents: UC_BR_*   branch kinds
//           UC_PUSH*  push-value selectors (including UC_PUSHBUS)
//           UC_BUS_*  data-bus operation kinds
//           TYPE_INTEGER, POP_FROM_ALU, bus_state_e
// ---------------------------------------------------------------------------
package cpu_mem_stage_pkg;

   // Branch kinds
   localparam logic [1:0] UC_BR_NONE     = 2'd0;
   localparam logic [1:0] UC_BR_REL      = 2'd1;
   localparam logic [1:0] UC_BR_ALU      = 2'd2;
   localparam logic [1:0] UC_BR_REL_COND = 2'd3;

   // Push-value selectors
   localparam logic [2:0] UC_PUSHALU  = 3'd0;
   localparam logic [2:0] UC_PUSHIMM  = 3'd1;
   localparam logic [2:0] UC_PUSHREG0 = 3'd2;
   localparam logic [2:0] UC_PUSHREG1 = 3'd3;
   localparam logic [2:0] UC_PUSHBUS  = 3'd4;

   // Data-bus operations
   localparam logic [1:0] UC_BUS_NONE = 2'd0;
   localparam logic [1:0] UC_BUS_RD   = 2'd1;
   localparam logic [1:0] UC_BUS_WR   = 2'd2;

   // Stack-entry type tag for plain integers
   localparam int TYPE_INTEGER = 1;

   // Pop-count value meaning "take the pop count from the ALU result"
   localparam int POP_FROM_ALU = 3;

   typedef enum logic [1:0] {
      BUS_IDLE = 2'd0,
      BUS_REQ  = 2'd1,
      BUS_DONE = 2'd2
   } bus_state_e;

endpackage

// File: rtl/cpu_mem_stage_busfsm.sv
// ---------------------------------------------------------------------------
// cpu_mem_stage_busfsm
// Purpose : Data-bus master for the memory stage. Runs one req/ack access per
//           bus instruction, stalls stage 3 while it is in flight and keeps
//           the captured read data / error flag for the DONE cycle.
// Build   : CPU_MEM_TIMEOUT_EN enables the REQ-cycle timeout counter; when
//           undefined, REQ waits for ack indefinitely and err_o is 0.
// Ports   : clk, rst_b (async, active-low)
//           valid_i, bus_op_i, addr_i, wrdata_i   stage-3 request side
//           stall_o   hold stage 3 (combinational)
//           done_o    FSM is in DONE (instruction may advance)
//           rddata_o  captured read data (all-ones after timeout)
//           err_o     captured timeout flag
//           req_o, we_o, addr_o, wrdata_o         registered bus master
//           ack_i, rddata_i                       bus slave response
// ---------------------------------------------------------------------------
module cpu_mem_stage_busfsm #(
   parameter int DATA_W  = 32,
   parameter int BUS_AW  = 8,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic              valid_i,
   input  logic [1:0]        bus_op_i,
   input  logic [BUS_AW-1:0] addr_i,
   input  logic [DATA_W-1:0] wrdata_i,
   output logic              stall_o,
   output logic              done_o,
   output logic [DATA_W-1:0] rddata_o,
   output logic              err_o,
   output logic              req_o,
   output logic              we_o,
   output logic [BUS_AW-1:0] addr_o,
   output logic [DATA_W-1:0] wrdata_o,
   input  logic              ack_i,
   input  logic [DATA_W-1:0] rddata_i
);
   import cpu_mem_stage_pkg::*;

   bus_state_e        state_q, state_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [BUS_AW-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wrdata_q, wrdata_d;
   logic [DATA_W-1:0] rddata_q, rddata_d;
   logic              err_q, err_d;
   logic              timeout_c;

`ifdef CPU_MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // cnt_q holds the number of completed REQ cycles; the current REQ cycle
   // is the last one allowed when TIMEOUT-1 have already elapsed.
   assign timeout_c = (cnt_q == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
`else
   localparam int unused_timeout = TIMEOUT;
   assign timeout_c = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q  <= BUS_IDLE;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wrdata_q <= '0;
         rddata_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wrdata_q <= wrdata_d;
         rddata_q <= rddata_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      req_d    = req_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wrdata_d = wrdata_q;
      rddata_d = rddata_q;
      err_d    = err_q;
      stall_o  = 1'b0;
`ifdef CPU_MEM_TIMEOUT_EN
      cnt_d    = cnt_q;
`endif
      case (state_q)
         BUS_IDLE: begin
            if (valid_i && (bus_op_i != UC_BUS_NONE)) begin
               stall_o  = 1'b1;
               state_d  = BUS_REQ;
               req_d    = 1'b1;
               we_d     = (bus_op_i == UC_BUS_WR);
               addr_d   = addr_i;
               wrdata_d = wrdata_i;
               err_d    = 1'b0;
`ifdef CPU_MEM_TIMEOUT_EN
               cnt_d    = '0;
`endif
            end
         end
         BUS_REQ: begin
            stall_o = 1'b1;
            if (ack_i) begin
               rddata_d = rddata_i;
               req_d    = 1'b0;
               state_d  = BUS_DONE;
            end else if (timeout_c) begin
               rddata_d = '1;
               err_d    = 1'b1;
               req_d    = 1'b0;
               state_d  = BUS_DONE;
            end else begin
`ifdef CPU_MEM_TIMEOUT_EN
               cnt_d = cnt_q + 1'b1;
`endif
            end
         end
         BUS_DONE: begin
            // Stage 3 advances this cycle; any ack seen here is stray.
            state_d = BUS_IDLE;
         end
         default: begin
            state_d = BUS_IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   assign done_o   = (state_q == BUS_DONE);
   assign rddata_o = rddata_q;
   assign err_o    = err_q;
   assign req_o    = req_q;
   assign we_o     = we_q;
   assign addr_o   = addr_q;
   assign wrdata_o = wrdata_q;

endmodule

// File: rtl/cpu_mem_stage.sv
// ---------------------------------------------------------------------------
// cpu_mem_stage
// Purpose : Stack CPU pipeline stage 3 -> 4. Resolves branches, selects the
//           stack push value and pop count, and performs one data-bus access
//           per bus instruction through cpu_mem_stage_busfsm.
// Build   : CPU_MEM_TIMEOUT_EN enables bus timeouts and bus_err_4a; when
//           undefined, bus_err_4a is tied 0.
// Ports   : clk, rst_b (async, active-low)
//           *_3a inputs   stage-3 instruction fields; stall_3a holds them
//           kill_4a, branch_target_4a   combinational redirect
//           *_4a outputs  registered stage-4 fields, bus_err_4a
//           bus__*        iobus master port (req/we/addr/wrdata registered)
// ---------------------------------------------------------------------------
module cpu_mem_stage #(
   parameter int DATA_W  = 32,
   parameter int TAG_W   = 3,
   parameter int PC_W    = 32,
   parameter int POP_W   = 11,
   parameter int BUS_AW  = 8,
   parameter int TIMEOUT = 15
) (
   input  logic                    clk,
   input  logic                    rst_b,
   input  logic                    valid_3a,
   output logic                    stall_3a,
   input  logic                    alu__cond_3a,
   input  logic [DATA_W-1:0]       alu__out_3a,
   input  logic [1:0]              c__branch_3a,
   input  logic [2:0]              c__to_push_3a,
   input  logic [1:0]              c__bus_3a,
   input  logic [47:0]             instruction_3a,
   input  logic [PC_W-1:0]         pc_3a,
   input  logic [TAG_W+DATA_W-1:0] r0_3a,
   input  logic [TAG_W+DATA_W-1:0] r1_3a,
   input  logic [POP_W-1:0]        st__to_pop_3a,
   output logic                    kill_4a,
   output logic [PC_W-1:0]         branch_target_4a,
   output logic                    valid_4a,
   output logic [2:0]              c__to_push_4a,
   output logic [PC_W-1:0]         pc_4a,
   output logic [POP_W-1:0]        st__to_pop_4a,
   output logic [TAG_W+DATA_W-1:0] st__to_push_4a,
   output logic                    bus_err_4a,
   output logic                    bus__req,
   output logic                    bus__we,
   output logic [BUS_AW-1:0]       bus__addr,
   output logic [DATA_W-1:0]       bus__wrdata,
   input  logic                    bus__ack,
   input  logic [DATA_W-1:0]       bus__rddata
);
   import cpu_mem_stage_pkg::*;

   localparam int ENTRY_W = TAG_W + DATA_W;

   logic               advance;
   logic               busfsm_done;
   logic               busfsm_err;
   logic [DATA_W-1:0]  busfsm_rddata;
   logic               take_branch;
   logic [PC_W-1:0]    rel_target;
   logic [PC_W-1:0]    target_c;
   logic [ENTRY_W-1:0] push_d;
   logic [POP_W-1:0]   pop_d;

   logic               valid_q;
   logic [2:0]         to_push_q;
   logic [PC_W-1:0]    pc_q;
   logic [POP_W-1:0]   pop_q;
   logic [ENTRY_W-1:0] push_q;

   logic unused_ok;
   assign unused_ok = ^{instruction_3a, alu__out_3a, r0_3a, r1_3a, busfsm_done};

   cpu_mem_stage_busfsm #(
      .DATA_W  (DATA_W),
      .BUS_AW  (BUS_AW),
      .TIMEOUT (TIMEOUT)
   ) u_busfsm (
      .clk      (clk),
      .rst_b    (rst_b),
      .valid_i  (valid_3a),
      .bus_op_i (c__bus_3a),
      .addr_i   (alu__out_3a[BUS_AW-1:0]),
      .wrdata_i (r0_3a[DATA_W-1:0]),
      .stall_o  (stall_3a),
      .done_o   (busfsm_done),
      .rddata_o (busfsm_rddata),
      .err_o    (busfsm_err),
      .req_o    (bus__req),
      .we_o     (bus__we),
      .addr_o   (bus__addr),
      .wrdata_o (bus__wrdata),
      .ack_i    (bus__ack),
      .rddata_i (bus__rddata)
   );

   assign advance = valid_3a & ~stall_3a;

   // Sign-extending cast of the 16-bit offset; the sum wraps at PC_W bits.
   assign rel_target = pc_3a + PC_W'($signed(instruction_3a[15:0]));

   always_comb begin
      take_branch = 1'b0;
      target_c    = '0;
      case (c__branch_3a)
         UC_BR_REL: begin
            take_branch = 1'b1;
            target_c    = rel_target;
         end
         UC_BR_REL_COND: begin
            take_branch = alu__cond_3a;
            target_c    = rel_target;
         end
         UC_BR_ALU: begin
            take_branch = 1'b1;
            target_c    = PC_W'(alu__out_3a);
         end
         default: begin
            take_branch = 1'b0;
            target_c    = '0;
         end
      endcase
   end

   // A bus instruction only advances in DONE, so its kill lands there too.
   assign kill_4a          = advance & take_branch;
   assign branch_target_4a = target_c;

   always_comb begin
      push_d = '0;
      case (c__to_push_3a)
         UC_PUSHALU:  push_d = {TAG_W'(TYPE_INTEGER), alu__out_3a};
         UC_PUSHIMM:  push_d = ENTRY_W'(instruction_3a);
         UC_PUSHREG0: push_d = r0_3a;
         UC_PUSHREG1: push_d = r1_3a;
         UC_PUSHBUS:  push_d = {TAG_W'(TYPE_INTEGER), busfsm_rddata};
         default:     push_d = '0;
      endcase
   end

   assign pop_d = (st__to_pop_3a == POP_W'(POP_FROM_ALU)) ? POP_W'(alu__out_3a)
                                                           : st__to_pop_3a;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         valid_q   <= 1'b0;
         to_push_q <= '0;
         pc_q      <= '0;
         pop_q     <= '0;
         push_q    <= '0;
      end else begin
         valid_q <= advance;
         if (advance) begin
            to_push_q <= c__to_push_3a;
            pc_q      <= pc_3a;
            pop_q     <= pop_d;
            push_q    <= push_d;
         end
      end
   end

`ifdef CPU_MEM_TIMEOUT_EN
   logic err_q;

   // Non-bus instructions retire with a clear error flag.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b)       err_q <= 1'b0;
      else if (advance) err_q <= busfsm_done & busfsm_err;
   end

   assign bus_err_4a = err_q;
`else
   logic unused_err;
   assign unused_err = busfsm_err;
   assign bus_err_4a = 1'b0;
`endif

   assign valid_4a       = valid_q;
   assign c__to_push_4a  = to_push_q;
   assign pc_4a          = pc_q;
   assign st__to_pop_4a  = pop_q;
   assign st__to_push_4a = push_q;

endmodule

// File: tb/tb_cpu_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_cpu_mem_stage
// Purpose : Self-checking bench for cpu_mem_stage with default parameters.
//           Directed cases followed by random plain and bus instructions,
//           each compared against a small behavioural model.
// ---------------------------------------------------------------------------
module tb_cpu_mem_stage;
   import cpu_mem_stage_pkg::*;

   localparam int TIMEOUT = 15;

   logic        clk;
   logic        rst_b;
   logic        valid_3a;
   logic        stall_3a;
   logic        alu__cond_3a;
   logic [31:0] alu__out_3a;
   logic [1:0]  c__branch_3a;
   logic [2:0]  c__to_push_3a;
   logic [1:0]  c__bus_3a;
   logic [47:0] instruction_3a;
   logic [31:0] pc_3a;
   logic [34:0] r0_3a;
   logic [34:0] r1_3a;
   logic [10:0] st__to_pop_3a;
   logic        kill_4a;
   logic [31:0] branch_target_4a;
   logic        valid_4a;
   logic [2:0]  c__to_push_4a;
   logic [31:0] pc_4a;
   logic [10:0] st__to_pop_4a;
   logic [34:0] st__to_push_4a;
   logic        bus_err_4a;
   logic        bus__req;
   logic        bus__we;
   logic [7:0]  bus__addr;
   logic [31:0] bus__wrdata;
   logic        bus__ack;
   logic [31:0] bus__rddata;

   int total = 0;
   int bad   = 0;

   cpu_mem_stage #(
      .DATA_W(32), .TAG_W(3), .PC_W(32), .POP_W(11), .BUS_AW(8), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst_b(rst_b), .valid_3a(valid_3a), .stall_3a(stall_3a),
      .alu__cond_3a(alu__cond_3a), .alu__out_3a(alu__out_3a),
      .c__branch_3a(c__branch_3a), .c__to_push_3a(c__to_push_3a),
      .c__bus_3a(c__bus_3a), .instruction_3a(instruction_3a), .pc_3a(pc_3a),
      .r0_3a(r0_3a), .r1_3a(r1_3a), .st__to_pop_3a(st__to_pop_3a),
      .kill_4a(kill_4a), .branch_target_4a(branch_target_4a),
      .valid_4a(valid_4a), .c__to_push_4a(c__to_push_4a), .pc_4a(pc_4a),
      .st__to_pop_4a(st__to_pop_4a), .st__to_push_4a(st__to_push_4a),
      .bus_err_4a(bus_err_4a), .bus__req(bus__req), .bus__we(bus__we),
      .bus__addr(bus__addr), .bus__wrdata(bus__wrdata), .bus__ack(bus__ack),
      .bus__rddata(bus__rddata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic exp_kill(input logic [1:0] br, input logic cond);
      if (br == UC_BR_REL || br == UC_BR_ALU) return 1'b1;
      if (br == UC_BR_REL_COND) return cond;
      return 1'b0;
   endfunction

   function automatic logic [31:0] exp_target(input logic [1:0] br, input logic [31:0] pc,
                                              input logic [47:0] ins, input logic [31:0] alu);
      int signed off;
      off = int'($signed(ins[15:0]));
      if (br == UC_BR_REL || br == UC_BR_REL_COND) return pc + 32'(off);
      if (br == UC_BR_ALU) return alu;
      return 32'h0;
   endfunction

   function automatic logic [34:0] exp_push(input logic [2:0] sel, input logic [31:0] alu,
                                            input logic [47:0] ins, input logic [34:0] r0,
                                            input logic [34:0] r1, input logic [31:0] rd);
      case (sel)
         3'd0: return {3'(TYPE_INTEGER), alu};
         3'd1: return ins[34:0];
         3'd2: return r0;
         3'd3: return r1;
         3'd4: return {3'(TYPE_INTEGER), rd};
         default: return 35'h0;
      endcase
   endfunction

   function automatic logic [10:0] exp_pop(input logic [10:0] p, input logic [31:0] alu);
      return (p == 11'(POP_FROM_ALU)) ? alu[10:0] : p;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_instr(input logic [1:0] br, input logic cond, input logic [31:0] alu,
                            input logic [2:0] psel, input logic [1:0] bus,
                            input logic [47:0] ins, input logic [31:0] pc,
                            input logic [34:0] r0, input logic [34:0] r1,
                            input logic [10:0] pop);
      valid_3a = 1'b1; c__branch_3a = br; alu__cond_3a = cond; alu__out_3a = alu;
      c__to_push_3a = psel; c__bus_3a = bus; instruction_3a = ins; pc_3a = pc;
      r0_3a = r0; r1_3a = r1; st__to_pop_3a = pop;
   endtask

   // Non-bus instruction: called at a negedge, returns at the next negedge.
   task automatic do_plain(input logic [1:0] br, input logic cond, input logic [31:0] alu,
                           input logic [2:0] psel, input logic [47:0] ins,
                           input logic [31:0] pc, input logic [34:0] r0,
                           input logic [34:0] r1, input logic [10:0] pop);
      set_instr(br, cond, alu, psel, UC_BUS_NONE, ins, pc, r0, r1, pop);
      #1;
      chk("plain_stall", stall_3a, 1'b0);
      chk("plain_kill", kill_4a, exp_kill(br, cond));
      chk("plain_target", branch_target_4a, exp_target(br, pc, ins, alu));
      @(negedge clk);
      chk("plain_valid4", valid_4a, 1'b1);
      chk("plain_push", st__to_push_4a, exp_push(psel, alu, ins, r0, r1, 32'h0));
      chk("plain_pop", st__to_pop_4a, exp_pop(pop, alu));
      chk("plain_pc", pc_4a, pc);
      chk("plain_psel", c__to_push_4a, psel);
      chk("plain_err", bus_err_4a, 1'b0);
      $display("txn plain br=%0d push_sel=%0d pc=%h push=%h pop=%h",
               br, psel, pc, st__to_push_4a, st__to_pop_4a);
   endtask

   // Bus instruction with ack on REQ cycle n (n=0: never ack, expect timeout).
   task automatic do_bus(input logic [1:0] op, input logic [31:0] alu, input logic [34:0] r0,
                         input logic [2:0] psel, input logic [1:0] br, input logic cond,
                         input logic [31:0] rd, input int n);
      logic [47:0] ins;
      logic [31:0] pc;
      logic [34:0] r1;
      logic [31:0] exp_rd;
      int stalls;
      int req_cycles;
      ins = {16'($urandom), $urandom};
      pc = $urandom;
      r1 = {3'($urandom), $urandom};
      stalls = 0;
      req_cycles = (n == 0) ? TIMEOUT : n;
      exp_rd = (n == 0) ? 32'hFFFF_FFFF : rd;
      set_instr(br, cond, alu, psel, op, ins, pc, r0, r1, 11'd2);
      #1;
      chk("bus_idle_stall", stall_3a, 1'b1);
      chk("bus_idle_kill", kill_4a, 1'b0);
      chk("bus_idle_req", bus__req, 1'b0);
      if (stall_3a) stalls++;
      for (int k = 1; k <= req_cycles; k++) begin
         @(negedge clk);
         chk("bus_req", bus__req, 1'b1);
         chk("bus_addr", bus__addr, alu[7:0]);
         chk("bus_we", bus__we, op == UC_BUS_WR);
         chk("bus_wrdata", bus__wrdata, r0[31:0]);
         chk("bus_req_kill", kill_4a, 1'b0);
         if (stall_3a) stalls++;
         bus__ack = (n != 0) && (k == n);
         bus__rddata = bus__ack ? rd : $urandom;
      end
      @(negedge clk);
      // DONE: a stray ack here must be ignored.
      bus__ack = 1'b1;
      bus__rddata = $urandom;
      #1;
      chk("bus_done_req", bus__req, 1'b0);
      chk("bus_done_stall", stall_3a, 1'b0);
      chk("bus_done_kill", kill_4a, exp_kill(br, cond));
      chk("bus_done_target", branch_target_4a, exp_target(br, pc, ins, alu));
      chk("bus_stall_cycles", 64'(stalls), 64'(1 + req_cycles));
      @(negedge clk);
      bus__ack = 1'b0;
      chk("bus_valid4", valid_4a, 1'b1);
      chk("bus_push", st__to_push_4a, exp_push(psel, alu, ins, r0, r1, exp_rd));
      chk("bus_pc", pc_4a, pc);
`ifdef CPU_MEM_TIMEOUT_EN
      chk("bus_err", bus_err_4a, n == 0);
`else
      chk("bus_err", bus_err_4a, 1'b0);
`endif
      chk("bus_after_req", bus__req, 1'b0);
      $display("txn bus op=%0d addr=%h acked_at=%0d push=%h err=%0d",
               op, alu[7:0], n, st__to_push_4a, bus_err_4a);
      valid_3a = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [47:0] ins;
      rst_b = 1'b0;
      set_instr(2'd0, 1'b0, 32'h0, 3'd0, 2'd0, 48'h0, 32'h0, 35'h0, 35'h0, 11'h0);
      valid_3a = 1'b0;
      bus__ack = 1'b0;
      bus__rddata = 32'h0;
      repeat (3) @(negedge clk);
      chk("rst_valid4", valid_4a, 1'b0);
      chk("rst_req", bus__req, 1'b0);
      chk("rst_stall", stall_3a, 1'b0);
      chk("rst_push", st__to_push_4a, 35'h0);
      chk("rst_addr", bus__addr, 8'h0);
      rst_b = 1'b1;
      @(negedge clk);

      // Directed: branches
      ins = 48'h0000_0000_FFF0;
      do_plain(UC_BR_REL_COND, 1'b1, 32'h0, UC_PUSHALU, ins, 32'h100, 35'h0, 35'h0, 11'd0);
      do_plain(UC_BR_REL_COND, 1'b0, 32'h0, UC_PUSHALU, ins, 32'h100, 35'h0, 35'h0, 11'd0);
      // Directed: immediate push
      ins = 48'h0005_1234_5678;
      do_plain(UC_BR_NONE, 1'b0, 32'h0, UC_PUSHIMM, ins, 32'h200, 35'h0, 35'h0, 11'd0);
      chk("dir_imm", st__to_push_4a, 35'h5_1234_5678);
      // Directed: pop counts
      do_plain(UC_BR_NONE, 1'b0, 32'h42, UC_PUSHALU, 48'h0, 32'h204, 35'h0, 35'h0, 11'd3);
      chk("dir_pop_alu", st__to_pop_4a, 11'h42);
      do_plain(UC_BR_NONE, 1'b0, 32'h42, UC_PUSHALU, 48'h0, 32'h208, 35'h0, 35'h0, 11'd2);
      chk("dir_pop_2", st__to_pop_4a, 11'h2);
      // Directed: read with ack on 4th REQ cycle
      do_bus(UC_BUS_RD, 32'h1C, 35'h0, UC_PUSHBUS, UC_BR_NONE, 1'b0, 32'hDEAD_BEEF, 4);
      chk("dir_rd_push", st__to_push_4a, {3'(TYPE_INTEGER), 32'hDEAD_BEEF});
      // Directed: write with ack on first REQ cycle, plus a relative branch
      do_bus(UC_BUS_WR, 32'h55, 35'h1_CAFE_F00D, UC_PUSHREG0, UC_BR_REL, 1'b0, 32'h0, 1);

      // Ack while idle is ignored
      valid_3a = 1'b0;
      bus__ack = 1'b1;
      @(negedge clk);
      chk("idle_ack_req", bus__req, 1'b0);
      chk("idle_ack_stall", stall_3a, 1'b0);
      chk("idle_valid4", valid_4a, 1'b0);
      bus__ack = 1'b0;

`ifdef CPU_MEM_TIMEOUT_EN
      do_bus(UC_BUS_RD, 32'h33, 35'h0, UC_PUSHBUS, UC_BR_NONE, 1'b0, 32'h0, 0);
      chk("to_push", st__to_push_4a, {3'(TYPE_INTEGER), 32'hFFFF_FFFF});
`endif

      // Random mix
      for (int t = 0; t < 40; t++) begin
         logic [1:0] br;
         logic [2:0] psel;
         logic [10:0] pop;
         ins = {16'($urandom), $urandom};
         br = 2'($urandom);
         pop = ($urandom_range(0, 3) == 0) ? 11'd3 : 11'($urandom);
         if ($urandom_range(0, 2) == 0) begin
            if ($urandom_range(0, 1) == 0)
               do_bus(UC_BUS_RD, $urandom, {3'($urandom), $urandom}, UC_PUSHBUS, br,
                      1'($urandom), $urandom, int'($urandom_range(1, 6)));
            else
               do_bus(UC_BUS_WR, $urandom, {3'($urandom), $urandom}, 3'($urandom_range(0, 3)),
                      br, 1'($urandom), $urandom, int'($urandom_range(1, 6)));
         end else begin
            psel = 3'($urandom_range(0, 7));
            if (psel == UC_PUSHBUS) psel = 3'd6;
            do_plain(br, 1'($urandom), $urandom, psel, ins, $urandom,
                     {3'($urandom), $urandom}, {3'($urandom), $urandom}, pop);
         end
      end

      // Reset on the 2nd REQ cycle of a write
      set_instr(UC_BR_NONE, 1'b0, 32'h77, UC_PUSHREG0, UC_BUS_WR, 48'h0, 32'h300,
                35'h0_1111_2222, 35'h0, 11'd0);
      @(negedge clk);
      @(negedge clk);
      chk("rstreq_pre_req", bus__req, 1'b1);
      rst_b = 1'b0;
      valid_3a = 1'b0;
      #1;
      chk("rstreq_req", bus__req, 1'b0);
      chk("rstreq_stall", stall_3a, 1'b0);
      chk("rstreq_valid4", valid_4a, 1'b0);
      chk("rstreq_push", st__to_push_4a, 35'h0);
      chk("rstreq_pc", pc_4a, 32'h0);
      chk("rstreq_addr", bus__addr, 8'h0);
      chk("rstreq_we", bus__we, 1'b0);
      chk("rstreq_wrdata", bus__wrdata, 32'h0);
      @(negedge clk);
      rst_b = 1'b1;
      bus__ack = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("late_ack_req", bus__req, 1'b0);
      chk("late_ack_stall", stall_3a, 1'b0);
      chk("late_ack_valid4", valid_4a, 1'b0);
      bus__ack = 1'b0;
      $display("txn reset_mid_req late_ack_ignored");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
